// File: rtl/mem_pkg.sv
// Shared definitions for the unified two-port memory: FSM encoding, port ids
// and default geometry/latency.
package mem_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LS    = 1'b1;

  localparam int DEF_ASIZE   = 16;
  localparam int DEF_DSIZE   = 16;
  localparam int DEF_LATENCY = 3;
  localparam int DEF_CW      = 4;

endpackage

// File: rtl/mem_rr_arb2.sv
// Two-way round-robin arbiter; the pointer records the last granted port and
// moves whenever a grant is issued (a grant is only issued to a requester).
module mem_rr_arb2
  import mem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic last_q;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave a value unassigned and infer a latch.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en) begin
      if (req0 && req1) begin
        gnt1 = (last_q == PORT_FETCH);
        gnt0 = ~gnt1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Reset to "fetch granted last" so the load/store port wins the first tie.
  always_ff @(posedge clk) begin
    if (rst)       last_q <= PORT_FETCH;
    else if (gnt0) last_q <= PORT_FETCH;
    else if (gnt1) last_q <= PORT_LS;
  end

endmodule

// File: rtl/mem_unified_arb.sv
// Unified fetch + load/store memory: round-robin arbitration, fixed LATENCY per
// access. Define MEM_BYTE_EN to add p1_be byte-enabled writes.
module mem_unified_arb
  import mem_pkg::*;
#(
  parameter int ASIZE   = DEF_ASIZE,
  parameter int DSIZE   = DEF_DSIZE,
  parameter int LATENCY = DEF_LATENCY,
  parameter int CW      = DEF_CW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p0_req,
  input  logic [ASIZE-1:0] p0_addr,
  output logic             p0_gnt,
  output logic             p0_rvalid,
  output logic [DSIZE-1:0] p0_rdata,
  input  logic             p1_req,
  input  logic             p1_wen,
  input  logic [ASIZE-1:0] p1_addr,
  input  logic [DSIZE-1:0] p1_wdata,
`ifdef MEM_BYTE_EN
  input  logic [DSIZE/8-1:0] p1_be,
`endif
  output logic             p1_gnt,
  output logic             p1_rvalid,
  output logic [DSIZE-1:0] p1_rdata
);

  localparam int DEPTH = 1 << ASIZE;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            accept, done;
  logic            port_l, wen_l;
  logic [ASIZE-1:0] addr_l;
  logic [DSIZE-1:0] wdata_l;
`ifdef MEM_BYTE_EN
  localparam int NB = DSIZE / 8;
  logic [NB-1:0]   be_l;
`endif
  logic [DSIZE-1:0] mem [DEPTH];

  // Grants are suppressed while busy and while reset is held.
  mem_rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .en   ((state_q == ST_IDLE) && !rst),
    .req0 (p0_req),
    .req1 (p1_req),
    .gnt0 (p0_gnt),
    .gnt1 (p1_gnt)
  );

  assign accept = p0_gnt | p1_gnt;
  assign done   = (state_q == ST_BUSY) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: if (accept) begin
        state_d = ST_BUSY;
        cnt_d   = CW'(LATENCY - 1);
      end
      ST_BUSY: if (cnt_q == '0) state_d = ST_IDLE;
               else             cnt_d   = cnt_q - CW'(1);
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request latch only matters while BUSY, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      port_l  <= p1_gnt ? PORT_LS : PORT_FETCH;
      wen_l   <= p1_gnt & p1_wen;
      addr_l  <= p1_gnt ? p1_addr : p0_addr;
      wdata_l <= p1_wdata;
`ifdef MEM_BYTE_EN
      be_l    <= p1_be;
`endif
    end
  end

  // NOTE: the storage array is deliberately not reset; a reset loop over every
  // word would prevent RAM inference. Reset only blocks an in-flight write.
  always_ff @(posedge clk) begin
    if (!rst && done && wen_l) begin
`ifdef MEM_BYTE_EN
      for (int b = 0; b < NB; b++)
        if (be_l[b]) mem[addr_l][b*8 +: 8] <= wdata_l[b*8 +: 8];
`else
      mem[addr_l] <= wdata_l;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      if (done && !wen_l) begin
        if (port_l == PORT_FETCH) begin
          p0_rvalid <= 1'b1;
          p0_rdata  <= mem[addr_l];
        end else begin
          p1_rvalid <= 1'b1;
          p1_rdata  <= mem[addr_l];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_unified_arb.sv
// Scoreboard bench for mem_unified_arb: stimulus pushes expected read responses,
// a negedge monitor pops and compares port, data and completion cycle.
module tb_mem_unified_arb;
  import mem_pkg::*;

  localparam int ASIZE   = DEF_ASIZE;
  localparam int DSIZE   = DEF_DSIZE;
  localparam int LATENCY = DEF_LATENCY;
  localparam int CW      = DEF_CW;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             p0_req = 1'b0, p1_req = 1'b0, p1_wen = 1'b0;
  logic [ASIZE-1:0] p0_addr = '0, p1_addr = '0;
  logic [DSIZE-1:0] p1_wdata = '0;
  logic             p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [DSIZE-1:0] p0_rdata, p1_rdata;
`ifdef MEM_BYTE_EN
  logic [DSIZE/8-1:0] p1_be = '1;
`endif

  mem_unified_arb #(.ASIZE(ASIZE), .DSIZE(DSIZE), .LATENCY(LATENCY), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(p0_gnt),
    .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_wen(p1_wen), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
`ifdef MEM_BYTE_EN
    .p1_be(p1_be),
`endif
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic             port;
    logic [DSIZE-1:0] data;
    int               due;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rvalid must match the oldest outstanding read.
  always @(negedge clk) begin
    if (p0_rvalid || p1_rvalid) begin
      exp_t e;
      check("rv_single_port", {31'd0, p0_rvalid & p1_rvalid}, 32'd0);
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rv_unexpected: p0_rvalid=%0b p1_rvalid=%0b at cycle %0d", p0_rvalid, p1_rvalid, cyc);
      end else begin
        e = sb.pop_front();
        check("rv_port", {31'd0, p1_rvalid}, {31'd0, e.port});
        check("rv_data", p1_rvalid ? p1_rdata : p0_rdata, e.data);
        check("rv_cycle", cyc, e.due);
      end
    end
  end

  // Wait (bounded) for this port's grant, then return the accept-edge cycle.
  task automatic wait_gnt(input logic port, output int k);
    int n = 0;
    k = -1;
    forever begin
      @(negedge clk);
      if (port ? p1_gnt : p0_gnt) break;
      if (++n > 50) begin
        n_vec++;
        n_err++;
        $display("FAIL gnt_timeout: port %0d got no grant within 50 cycles", port);
        return;
      end
    end
    check("gnt_exclusive", {31'd0, port ? p0_gnt : p1_gnt}, 32'd0);
    @(posedge clk);
    #1;
    k = cyc;
  endtask

  task automatic access(input logic port, input logic wen, input logic [ASIZE-1:0] addr,
                        input logic [DSIZE-1:0] wdata, input logic [DSIZE-1:0] exp, output int k);
    if (port) begin
      p1_req = 1'b1; p1_wen = wen; p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_req = 1'b1; p0_addr = addr;
    end
    wait_gnt(port, k);
    if (port) p1_req = 1'b0; else p0_req = 1'b0;
    if (k >= 0 && !(port && wen)) sb.push_back('{port, exp, k + LATENCY});
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d reads still pending", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k2, e0, kprev;
    logic [DSIZE-1:0] rd_exp;

    // Reset values, with both requests high to show grants are blocked.
    repeat (2) @(posedge clk);
    #1;
    p0_req = 1'b1;
    p1_req = 1'b1;
    @(negedge clk);
    check("rst_p0_gnt", {31'd0, p0_gnt}, 32'd0);
    check("rst_p1_gnt", {31'd0, p1_gnt}, 32'd0);
    check("rst_p0_rvalid", {31'd0, p0_rvalid}, 32'd0);
    check("rst_p1_rvalid", {31'd0, p1_rvalid}, 32'd0);
    check("rst_p0_rdata", p0_rdata, 32'd0);
    check("rst_p1_rdata", p1_rdata, 32'd0);
    p0_req = 1'b0;
    p1_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Write then fetch-port read.
    access(1'b1, 1'b1, 16'h0010, 16'h1234, '0, k);
    access(1'b0, 1'b0, 16'h0010, '0, 16'h1234, k);
    drain();
    check("p0_rdata_hold", p0_rdata, 16'h1234);
    check("p0_rvalid_low", {31'd0, p0_rvalid}, 32'd0);

    // Back-to-back write/read on p1.
    access(1'b1, 1'b1, 16'h0020, 16'hBEEF, '0, k);
    access(1'b1, 1'b0, 16'h0020, '0, 16'hBEEF, k2);
    check("b2b_accept_gap", k2 - k, LATENCY + 1);
    drain();

    // Held p0 requests: one accept per LATENCY+1 cycles, correct data each.
    p0_req = 1'b1;
    kprev = 0;
    for (int i = 0; i < 4; i++) begin
      p0_addr = (i % 2 == 1) ? 16'h0020 : 16'h0010;
      rd_exp  = (i % 2 == 1) ? 16'hBEEF : 16'h1234;
      wait_gnt(1'b0, k);
      if (k >= 0) sb.push_back('{1'b0, rd_exp, k + LATENCY});
      if (i > 0) check("p0_stream_gap", k - kprev, LATENCY + 1);
      kprev = k;
    end
    p0_req = 1'b0;
    drain();

    // Contention from the first IDLE after reset: p1, p0, p1, p0.
    rst = 1'b1;
    p0_req = 1'b1; p0_addr = 16'h0010;
    p1_req = 1'b1; p1_wen = 1'b1; p1_addr = 16'h0050; p1_wdata = 16'h7777;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      @(negedge clk);
      while (!(p0_gnt || p1_gnt) && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("contend_winner_p1", {31'd0, p1_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("contend_onehot", {31'd0, p0_gnt & p1_gnt}, 32'd0);
      @(posedge clk);
      #1;
      if (i % 2 == 1) sb.push_back('{1'b0, 16'h1234, cyc + LATENCY});
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    drain();
    access(1'b1, 1'b0, 16'h0050, '0, 16'h7777, k);
    drain();

    // Reset mid-access: the 0xAAAA write must be abandoned.
    access(1'b1, 1'b1, 16'h0030, 16'h5555, '0, k);
    access(1'b1, 1'b1, 16'h0030, 16'hAAAA, '0, k);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_p1_rdata", p1_rdata, 32'd0);
    check("midrst_rvalid", {31'd0, p0_rvalid | p1_rvalid}, 32'd0);
    e0 = cyc;
    access(1'b1, 1'b0, 16'h0030, '0, 16'h5555, k);
    check("midrst_idle_accept", k - e0, 1);
    drain();
    for (int i = 0; i < LATENCY + 1; i++) begin
      @(negedge clk);
      check("midrst_quiet", {31'd0, p0_rvalid | p1_rvalid}, 32'd0);
    end

`ifdef MEM_BYTE_EN
    // Byte-enabled writes on a 16-bit word.
    p1_be = 2'b11;
    access(1'b1, 1'b1, 16'h0040, 16'h1111, '0, k);
    p1_be = 2'b10;
    access(1'b1, 1'b1, 16'h0040, 16'hFFFF, '0, k);
    access(1'b1, 1'b0, 16'h0040, '0, 16'hFF11, k);
    drain();
    p1_be = 2'b00;
    access(1'b1, 1'b1, 16'h0040, 16'h0000, '0, k);
    p1_be = 2'b11;
    access(1'b0, 1'b0, 16'h0040, '0, 16'hFF11, k);
    drain();
`endif

    repeat (2) @(posedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_unified_arb.md
# mem_unified_arb

Two-port, parametrised-latency unified memory for the phase-2 CPU. It serves an instruction-fetch port and a load/store port from one storage array. A round-robin arbiter serialises the two ports, and each accepted access holds the array busy for exactly LATENCY cycles before it completes. It replaces the single-port fixed-latency memory and adds per-port handshakes, arbitration, an explicit read-valid and optional byte-enable writes.

## Interface
- ASIZE, 16: address width in words; depth is 2**ASIZE words.
- DSIZE, 16: data width; must be a multiple of 8.
- LATENCY, 3: cycles from acceptance to completion; legal range 1..15.
- CW, 4: width of the busy counter; must satisfy 2**CW > LATENCY.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- p0_req  in  1  fetch-port request; read only.
- p0_addr  in  ASIZE  fetch address.
- p0_gnt  out  1  fetch request accepted this cycle.
- p0_rvalid  out  1  fetch data valid; one-cycle pulse.
- p0_rdata  out  DSIZE  fetch read data.
- p1_req  in  1  load/store-port request.
- p1_wen  in  1  1 = write, 0 = read.
- p1_addr  in  ASIZE  load/store address.
- p1_wdata  in  DSIZE  write data.
- p1_be  in  DSIZE/8  byte enables; present only with MEM_BYTE_EN.
- p1_gnt  out  1  load/store request accepted this cycle.
- p1_rvalid  out  1  load data valid; one-cycle pulse; never pulses for writes.
- p1_rdata  out  DSIZE  load read data.

## Operation
- FSM states:
  - IDLE: gnt may assert.
  - BUSY: cnt counts down from LATENCY-1.
  - IDLE→BUSY on acceptance; BUSY→IDLE when cnt==0.
- Acceptance: in IDLE, gnt is combinational from the req inputs and the priority pointer. At most one gnt is high. An accept happens at an edge where req && gnt.
- Arbitration:
  - Only one port requesting: that port wins.
  - Both requesting: the port not holding the last grant wins.
  - The pointer resets so that p1 wins the first contention.
- On accept:
  - latch port id, wen, addr, wdata (and be);
  - load cnt = LATENCY-1;
  - requests arriving during BUSY are ignored and not queued. The requester holds req until gnt.
- Completion at the edge where BUSY has cnt==0:
  - Write: the array word updates at that edge.
  - Read: rdata is registered from the array and the matching rvalid is set for one cycle.
- Data ordering: accesses are serialised, so a read accepted after a write completes returns the new data.
- rdata holds its last value when rvalid is low.
- The array is not reset; its contents are undefined until written.

## Timing
- Reset values:
  - p0_gnt = p1_gnt = 0 during rst.
  - p0_rvalid = p1_rvalid = 0.
  - p0_rdata = p1_rdata = 0.
  - FSM in IDLE, cnt = 0, priority pointer = p1.
- Accept at edge k, then:
  - the write commits at edge k+LATENCY;
  - for a read, rvalid is high for the cycle after edge k+LATENCY.
- The next gnt is possible in that same cycle, with accept at edge k+LATENCY+1. Peak throughput is one access per LATENCY+1 cycles.
- LATENCY=1: completion at edge k+1; behaviour otherwise identical.
- Reset mid-access: the access is abandoned, no write, no rvalid, and the FSM returns to IDLE.
- req deasserted after accept: no effect; the access completes.

## Configuration
- MEM_BYTE_EN defined:
  - p1_be exists.
  - A write updates only the bytes whose be bit is 1.
  - be == 0 consumes a slot but leaves memory unchanged.
- MEM_BYTE_EN undefined:
  - no p1_be port;
  - every write updates the full word.

## Structure
- Shared package `mem_pkg` holds:
  - the state encoding (ST_IDLE, ST_BUSY);
  - port-id constants (PORT_FETCH=0, PORT_LS=1);
  - the default ASIZE, DSIZE and LATENCY constants.
- One sub-module, `mem_rr_arb2`: 2-way round-robin arbiter with a pointer update on accept. The FSM, request latch and array stay in the top module.

## Test plan
- Reset then single read, LATENCY=3:
  - write 0x1234 to addr 0x0010 via p1 and wait for completion;
  - p0 read of 0x0010 accepted at edge k gives p0_rvalid=1 and p0_rdata=0x1234 in the cycle after edge k+3, with no p1_rvalid.
- Contention: p0 and p1 both request at the first IDLE after reset.
  - p1 is granted first, then p0 on the next IDLE.
  - Hold both requests: grants alternate p1, p0, p1, p0.
- Back-to-back: p1 writes 0xBEEF to 0x0020, then a p1 read of 0x0020.
  - Read is accepted at edge k+4.
  - p1_rdata=0xBEEF and p1_rvalid pulses exactly once.
- Reset mid-access: assert rst one cycle after accepting a write of 0xAAAA to 0x0030 that holds 0x5555.
  - A later read returns 0x5555.
  - No rvalid during or after the reset.
- With MEM_BYTE_EN: word 0x0040 holds 0x1111; write 0xFFFF with be=2'b10.
  - A read returns 0xFF11.
  - be=2'b00 leaves the word unchanged.
- LATENCY=1 build: one read every 2 cycles on p0, rvalid high on alternate cycles, with correct data each time.
